// File: rtl/data_mem_stage_if.sv
// Request/response bundle between the EX-MEM register and the data-memory stage.
//   master : CPU pipeline side, drives the request, observes the WB-aligned results
//   slave  : data_mem_stage side
// Request  : iAddr (byte address), iWriteData (LSB-justified store data),
//            iRD / iWR (load / store this cycle), iFunct3 (size and sign)
// Response : oLoadData_wb, oLoadValid_wb, oFault_wb, oStoreDone_wb
//            (all describe the request made one cycle earlier)
interface data_mem_stage_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32
);
  logic [ADDRWIDTH-1:0] iAddr;
  logic [DATAWIDTH-1:0] iWriteData;
  logic                 iRD;
  logic                 iWR;
  logic [2:0]           iFunct3;
  logic [DATAWIDTH-1:0] oLoadData_wb;
  logic                 oLoadValid_wb;
  logic                 oFault_wb;
  logic                 oStoreDone_wb;

  modport master (
    output iAddr, iWriteData, iRD, iWR, iFunct3,
    input  oLoadData_wb, oLoadValid_wb, oFault_wb, oStoreDone_wb
  );

  modport slave (
    input  iAddr, iWriteData, iRD, iWR, iFunct3,
    output oLoadData_wb, oLoadValid_wb, oFault_wb, oStoreDone_wb
  );
endinterface

// File: rtl/data_mem_stage.sv
// Data-memory access stage of the 5-stage RISC-V pipeline (EX-MEM -> MEM-WB).
// Holds a word-organised synchronous RAM; stores use byte lanes (SB/SH/SW),
// loads (LB/LH/LW/LBU/LHU) read with one cycle of latency and are lane-selected
// and extended from registered address/funct3 so the result is WB-aligned.
// Ports:
//   Clk   : clock, all state changes on the rising edge
//   Reset : synchronous active-high; clears the WB outputs, never touches the RAM
//   bus   : data_mem_stage_if.slave (request in, WB-aligned results out)
module data_mem_stage #(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input logic              Clk,
  input logic              Reset,
  data_mem_stage_if.slave  bus
);

  localparam int IDXW = $clog2(DEPTH_WORDS);

  logic [DATAWIDTH-1:0] r_mem [DEPTH_WORDS];

  logic [DATAWIDTH-1:0] r_rdata;
  logic [1:0]           r_lane;
  logic [2:0]           r_funct3;
  logic                 r_load_valid;
  logic                 r_fault;
  logic                 r_store_done;

  logic [IDXW-1:0]      w_idx;
  logic [1:0]           w_lane;
  logic                 w_store_legal;
  logic                 w_load_legal;
  logic                 w_misalign;
  logic                 w_is_store;
  logic                 w_is_load;
  logic                 w_do_store;
  logic                 w_do_load;
  logic                 w_fault;
  logic [3:0]           w_be;
  logic [DATAWIDTH-1:0] w_wdata;
  logic [DATAWIDTH-1:0] w_shifted;
  logic [DATAWIDTH-1:0] w_ext;
  logic                 w_unused_addr;

  // Address bits above the RAM index are ignored, so accesses wrap.
  assign w_idx         = bus.iAddr[IDXW+1:2];
  assign w_lane        = bus.iAddr[1:0];
  assign w_unused_addr = ^bus.iAddr[ADDRWIDTH-1:IDXW+2];

  always_comb begin
    w_store_legal = 1'b0;
    w_load_legal  = 1'b0;
    case (bus.iFunct3)
      3'b000, 3'b001, 3'b010: begin
        w_store_legal = 1'b1;
        w_load_legal  = 1'b1;
      end
      3'b100, 3'b101: w_load_legal = 1'b1;
      default: ;
    endcase
  end

  // Size is funct3[1:0]; illegal encodings are caught separately, so only
  // halfword and word sizes have alignment requirements here.
  always_comb begin
    w_misalign = 1'b0;
    case (bus.iFunct3[1:0])
      2'b01:   w_misalign = w_lane[0];
      2'b10:   w_misalign = (w_lane != 2'b00);
      default: w_misalign = 1'b0;
    endcase
  end

  // A simultaneous read and write request is treated as a store only.
  assign w_is_store = bus.iWR;
  assign w_is_load  = bus.iRD & ~bus.iWR;

  assign w_do_store = w_is_store & w_store_legal & ~w_misalign & ~Reset;
  assign w_do_load  = w_is_load  & w_load_legal  & ~w_misalign;
  assign w_fault    = (w_is_store & (~w_store_legal | w_misalign)) |
                      (w_is_load  & (~w_load_legal  | w_misalign));

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.iWriteData;
    case (bus.iFunct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{bus.iWriteData[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.iWriteData[15:0]}};
      end
      2'b10: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // RAM port kept free of reset so it maps onto block memory; Reset gating
  // of the write enable lives in w_do_store.
  always_ff @(posedge Clk) begin
    if (w_do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
    if (w_do_load) r_rdata <= r_mem[w_idx];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lane       <= 2'b00;
      r_funct3     <= 3'b000;
      r_load_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_store_done <= 1'b0;
    end else begin
      r_lane       <= w_lane;
      r_funct3     <= bus.iFunct3;
      r_load_valid <= w_do_load;
      r_fault      <= w_fault;
      r_store_done <= w_do_store;
    end
  end

  // Extraction works only on registered values, so the result moves only at edges.
  assign w_shifted = r_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_ext = '0;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_ext = r_rdata;
      3'b100:  w_ext = {24'd0, w_shifted[7:0]};
      3'b101:  w_ext = {16'd0, w_shifted[15:0]};
      default: w_ext = '0;
    endcase
  end

  // Masking with the valid flag keeps stale or uninitialised RAM data off the bus.
  assign bus.oLoadData_wb  = r_load_valid ? w_ext : '0;
  assign bus.oLoadValid_wb = r_load_valid;
  assign bus.oFault_wb     = r_fault;
  assign bus.oStoreDone_wb = r_store_done;

endmodule
